wlan_scrambler_par: RTL and testbench

//  Parametrised 802.11 frame-synchronous scrambler/descrambler, polynomial x^7+x^4+1, processing DW bits per beat.

---
 rtl/wlan_scr_pkg.sv | 25 ++
 rtl/wlan_lfsr_step.sv | 41 ++++
 rtl/wlan_scrambler_par.sv | 127 ++++++++++++
 tb/tb_wlan_scrambler_par.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlan_scr_pkg.sv
// Shared constants and types for the 802.11 x^7+x^4+1 frame-synchronous scrambler.
package wlan_scr_pkg;

  localparam int SEED_LEN = 7;
  localparam int TAP_A    = 6;
  localparam int TAP_B    = 3;

  localparam logic [SEED_LEN-1:0] DEFAULT_SEED = 7'h7F;
  localparam logic [2:0]          SYNC_BITS    = 3'd7;

  localparam logic MODE_SCRAMBLE   = 1'b0;
  localparam logic MODE_DESCRAMBLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } scr_state_t;

  // An all-zero state would lock the LFSR at zero, so it is never used as a seed.
  function automatic logic [SEED_LEN-1:0] fix_seed(input logic [SEED_LEN-1:0] seed);
    return (seed == '0) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/wlan_lfsr_step.sv
// Combinational DW-bit unroll of the scrambler LFSR; bit 0 of the beat is processed first.
module wlan_lfsr_step
  import wlan_scr_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [SEED_LEN-1:0] s,
  input  logic [DW-1:0]       d,
  input  logic [2:0]          bitcnt,
  input  logic                sync_en,
  output logic [SEED_LEN-1:0] s_next,
  output logic [DW-1:0]       o,
  output logic [2:0]          bitcnt_next
);

  logic [SEED_LEN-1:0] s_v;
  logic [2:0]          cnt_v;
  logic                fb;

  always_comb begin
    s_v   = s;
    cnt_v = bitcnt;
    fb    = 1'b0;
    o     = '0;
    for (int b = 0; b < DW; b++) begin
      fb = s_v[TAP_A] ^ s_v[TAP_B];
      // While syncing, received bits are the keystream itself and are shifted in directly.
      if (sync_en && (cnt_v < SYNC_BITS)) begin
        o[b]  = 1'b0;
        s_v   = {s_v[SEED_LEN-2:0], d[b]};
        cnt_v = cnt_v + 3'd1;
      end else begin
        o[b]  = d[b] ^ fb;
        s_v   = {s_v[SEED_LEN-2:0], fb};
      end
    end
    s_next      = s_v;
    bitcnt_next = cnt_v;
  end

endmodule

// File: rtl/wlan_scrambler_par.sv
// 802.11 frame-synchronous scrambler/descrambler, DW bits per beat, valid/ready on both sides.
module wlan_scrambler_par
  import wlan_scr_pkg::*;
#(
  parameter int DW       = 4,
  parameter int SEED_LEN = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [SEED_LEN-1:0] seed_in,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                sync_done
);

  scr_state_t          state;
  scr_state_t          state_next;
  logic [SEED_LEN-1:0] s_q;
  logic [2:0]          bitcnt_q;

  logic                accept;
  logic [SEED_LEN-1:0] s_start;
  logic [SEED_LEN-1:0] s_next;
  logic [2:0]          cnt_start;
  logic [2:0]          cnt_next;
  logic                sync_en;
  logic                beat_sync;
  logic [DW-1:0]       o_beat;

  logic [DW-1:0]       data_p1;
  logic                vld_p1;
  logic                last_p1;
  logic                sync_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat arriving in IDLE starts a new frame, so it uses the freshly loaded state.
  always_comb begin
    s_start   = s_q;
    cnt_start = bitcnt_q;
    sync_en   = (state == SYNC);
    if (state == IDLE) begin
      cnt_start = '0;
      if (mode == MODE_SCRAMBLE) begin
        s_start = fix_seed(seed_in);
        sync_en = 1'b0;
      end else begin
        s_start = '0;
        sync_en = 1'b1;
      end
    end
  end

  wlan_lfsr_step #(
    .DW(DW)
  ) u_step (
    .s          (s_start),
    .d          (in_data),
    .bitcnt     (cnt_start),
    .sync_en    (sync_en),
    .s_next     (s_next),
    .o          (o_beat),
    .bitcnt_next(cnt_next)
  );

  always_comb begin
    beat_sync = 1'b0;
    if (sync_en) begin
      beat_sync = (cnt_next == SYNC_BITS);
    end else if (state == IDLE) begin
      beat_sync = 1'b1;
    end

    if (in_last) begin
      state_next = IDLE;
    end else if (sync_en && (cnt_next != SYNC_BITS)) begin
      state_next = SYNC;
    end else begin
      state_next = RUN;
    end
  end

  // Stage p1: single output register; sync_done travels with the beat it describes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      s_q      <= '0;
      bitcnt_q <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      sync_p1  <= 1'b0;
    end else begin
      if (accept) begin
        state    <= state_next;
        s_q      <= s_next;
        bitcnt_q <= cnt_next;
        data_p1  <= o_beat;
        vld_p1   <= 1'b1;
        last_p1  <= in_last;
        sync_p1  <= ((state == IDLE) ? 1'b0 : sync_p1) | beat_sync;
      end else begin
        if (out_ready) begin
          vld_p1 <= 1'b0;
        end
        // Clear only once the frame's final beat has left the output register.
        if ((state == IDLE) && in_ready) begin
          sync_p1 <= 1'b0;
        end
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign sync_done = sync_p1;

endmodule

// File: tb/tb_wlan_scrambler_par.sv
// Directed bench for wlan_scrambler_par with a DW=8 and a DW=4 instance.
module tb_wlan_scrambler_par;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       mode8 = 1'b0, in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b1;
  logic [6:0] seed8 = '0;
  logic [7:0] in_data8 = '0;
  logic [7:0] out_data8;
  logic       in_ready8, out_valid8, out_last8, sync_done8;

  logic       mode4 = 1'b0, in_valid4 = 1'b0, in_last4 = 1'b0, out_ready4 = 1'b1;
  logic [6:0] seed4 = '0;
  logic [3:0] in_data4 = '0;
  logic [3:0] out_data4;
  logic       in_ready4, out_valid4, out_last4, sync_done4;

  int checks = 0;
  int errors = 0;

  logic [39:0] frame;
  logic [39:0] scr_ref_bits;

  wlan_scrambler_par #(.DW(8)) u8 (
    .clk(clk), .reset(reset), .mode(mode8), .seed_in(seed8),
    .in_data(in_data8), .in_valid(in_valid8), .in_last(in_last8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_last(out_last8),
    .out_ready(out_ready8), .sync_done(sync_done8)
  );

  wlan_scrambler_par #(.DW(4)) u4 (
    .clk(clk), .reset(reset), .mode(mode4), .seed_in(seed4),
    .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_last(out_last4),
    .out_ready(out_ready4), .sync_done(sync_done4)
  );

  // Bit-serial 802.11 scrambler: registers x1..x7, keystream bit = x7 ^ x4.
  function automatic logic [39:0] scr_ref(input logic [6:0] seed, input logic [39:0] d, input int n);
    logic [7:1] x;
    logic       k;
    logic [39:0] r;
    x = seed;
    r = '0;
    for (int i = 0; i < n; i++) begin
      k = x[7] ^ x[4];
      r[i] = d[i] ^ k;
      x = {x[6:1], k};
    end
    return r;
  endfunction

  task automatic send8(input logic m, input logic [6:0] seed, input logic [7:0] d, input logic last,
                       output logic [7:0] o, output logic v, output logic sd, output logic ol);
    @(negedge clk);
    mode8 = m; seed8 = seed; in_data8 = d; in_last8 = last; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    o = out_data8; v = out_valid8; sd = sync_done8; ol = out_last8;
  endtask

  task automatic idle8();
    @(negedge clk);
    in_valid8 = 1'b0; in_last8 = 1'b0;
  endtask

  task automatic run4(input logic m, input logic [6:0] seed, input logic [39:0] bits, input int nb,
                      input logic stall, output logic [39:0] obits, output logic [9:0] sdv);
    int sent, got, cyc;
    logic acc, oh, exp_rdy;
    sent = 0; got = 0; cyc = 0; obits = '0; sdv = '0;
    while (got < nb && cyc < 200) begin
      @(negedge clk);
      out_ready4 = stall ? ((cyc % 2) == 0) : 1'b1;
      in_valid4  = (sent < nb);
      in_data4   = (sent < nb) ? bits[sent*4 +: 4] : 4'h0;
      in_last4   = (sent == nb - 1);
      mode4 = m; seed4 = seed;
      #1;
      exp_rdy = !(out_valid4 && !out_ready4);
      checks++;
      if (in_ready4 !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready cyc %0d: got %b required %b", cyc, in_ready4, exp_rdy);
      end
      acc = in_valid4 && in_ready4;
      oh  = out_valid4 && out_ready4;
      if (oh) begin
        obits[got*4 +: 4] = out_data4;
        sdv[got] = sync_done4;
        checks++;
        if (out_last4 !== (got == nb - 1)) begin
          errors++;
          $display("FAIL out_last beat %0d: got %b required %b", got, out_last4, (got == nb - 1));
        end
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    checks++;
    if (got != nb) begin
      errors++;
      $display("FAIL run4 timeout: got %0d beats required %0d", got, nb);
    end
    @(negedge clk);
    in_valid4 = 1'b0; in_last4 = 1'b0; out_ready4 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0 || out_data8 !== 8'h00 || out_last8 !== 1'b0 || sync_done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: valid %b data %h last %b sync %b required all 0",
               out_valid8, out_data8, out_last8, sync_done8);
    end
    checks++;
    if (out_valid4 !== 1'b0 || out_data4 !== 4'h0 || out_last4 !== 1'b0 || sync_done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: valid %b data %h last %b sync %b required all 0",
               out_valid4, out_data4, out_last4, sync_done4);
    end
    checks++;
    if (in_ready8 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b %b required 1 1", in_ready8, in_ready4);
    end
    reset = 1'b1;
  endtask

  task automatic test_scramble_zero();
    logic [7:0] o; logic v, sd, ol;
    send8(1'b0, 7'h7F, 8'h00, 1'b0, o, v, sd, ol);
    checks++;
    if (o !== 8'h70 || v !== 1'b1 || ol !== 1'b0) begin
      errors++;
      $display("FAIL scr_beat0: data %h valid %b last %b required 70 1 0", o, v, ol);
    end
    checks++;
    if (sd !== 1'b1) begin
      errors++;
      $display("FAIL scr_sync: got %b required 1", sd);
    end
    send8(1'b0, 7'h7F, 8'h00, 1'b1, o, v, sd, ol);
    checks++;
    if (o !== 8'h4F || v !== 1'b1 || ol !== 1'b1) begin
      errors++;
      $display("FAIL scr_beat1: data %h valid %b last %b required 4f 1 1", o, v, ol);
    end
    idle8();
  endtask

  task automatic test_seed_zero();
    logic [7:0] o; logic v, sd, ol;
    send8(1'b0, 7'h00, 8'h00, 1'b0, o, v, sd, ol);
    checks++;
    if (o !== 8'h70 || sd !== 1'b1) begin
      errors++;
      $display("FAIL seed0_beat0: data %h sync %b required 70 1", o, sd);
    end
    send8(1'b0, 7'h00, 8'h00, 1'b1, o, v, sd, ol);
    checks++;
    if (o !== 8'h4F) begin
      errors++;
      $display("FAIL seed0_beat1: data %h required 4f", o);
    end
    idle8();
  endtask

  task automatic test_back_to_back();
    logic [7:0] o; logic v, sd, ol;
    logic [6:0] seeds [3];
    seeds[0] = 7'h7F; seeds[1] = 7'h00; seeds[2] = 7'h7F;
    for (int i = 0; i < 3; i++) begin
      send8(1'b0, seeds[i], 8'h00, 1'b1, o, v, sd, ol);
      checks++;
      if (o !== 8'h70 || v !== 1'b1 || ol !== 1'b1 || sd !== 1'b1) begin
        errors++;
        $display("FAIL b2b frame %0d: data %h valid %b last %b sync %b required 70 1 1 1", i, o, v, ol, sd);
      end
    end
    // Mode and seed changes on a later beat of the frame are ignored.
    send8(1'b0, 7'h7F, 8'h00, 1'b0, o, v, sd, ol);
    send8(1'b1, 7'h11, 8'h00, 1'b1, o, v, sd, ol);
    checks++;
    if (o !== 8'h4F || sd !== 1'b1) begin
      errors++;
      $display("FAIL midframe_mode: data %h sync %b required 4f 1", o, sd);
    end
    idle8();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] o; logic v, sd, ol;
    for (int i = 0; i < 3; i++) send8(1'b0, 7'h7F, 8'h00, 1'b0, o, v, sd, ol);
    @(negedge clk);
    in_valid8 = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || sync_done8 !== 1'b0 || out_data8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: valid %b sync %b data %h required 0 0 00", out_valid8, sync_done8, out_data8);
    end
    @(negedge clk);
    reset = 1'b1;
    send8(1'b0, 7'h7F, 8'h00, 1'b1, o, v, sd, ol);
    checks++;
    if (o !== 8'h70 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_restart: data %h valid %b required 70 1", o, v);
    end
    idle8();
  endtask

  task automatic test_loopback();
    logic [39:0] scr, desc;
    logic [9:0]  sd1, sd2;
    frame = {8'($urandom()), 32'($urandom())};
    frame[6:0] = 7'b0;
    scr_ref_bits = scr_ref(7'h5D, frame, 40);
    run4(1'b0, 7'h5D, frame, 10, 1'b0, scr, sd1);
    checks++;
    if (scr !== scr_ref_bits) begin
      errors++;
      $display("FAIL loop_scramble: got %h required %h", scr, scr_ref_bits);
    end
    checks++;
    if (sd1 !== 10'h3FF) begin
      errors++;
      $display("FAIL loop_scr_sync: got %b required 1111111111", sd1);
    end
    run4(1'b1, 7'h00, scr, 10, 1'b0, desc, sd2);
    checks++;
    if (desc !== frame) begin
      errors++;
      $display("FAIL loop_descramble: got %h required %h", desc, frame);
    end
    checks++;
    if (desc[6:0] !== 7'b0) begin
      errors++;
      $display("FAIL loop_sync_bits: got %b required 0000000", desc[6:0]);
    end
    checks++;
    if (sd2 !== 10'b1111111110) begin
      errors++;
      $display("FAIL loop_desc_sync: got %b required 1111111110", sd2);
    end
    checks++;
    if (sync_done4 !== 1'b0) begin
      errors++;
      $display("FAIL sync_clear_idle: got %b required 0", sync_done4);
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] scr;
    logic [9:0]  sd;
    run4(1'b0, 7'h5D, frame, 10, 1'b1, scr, sd);
    checks++;
    if (scr !== scr_ref_bits) begin
      errors++;
      $display("FAIL stall_stream: got %h required %h", scr, scr_ref_bits);
    end
  endtask

  task automatic test_short_descramble();
    logic [39:0] o;
    logic [9:0]  sd;
    run4(1'b1, 7'h00, 40'h00_0000_000B, 1, 1'b0, o, sd);
    checks++;
    if (o[3:0] !== 4'h0 || sd[0] !== 1'b0) begin
      errors++;
      $display("FAIL short_frame: data %h sync %b required 0 0", o[3:0], sd[0]);
    end
    checks++;
    if (sync_done4 !== 1'b0) begin
      errors++;
      $display("FAIL short_sync_idle: got %b required 0", sync_done4);
    end
    // 802.11 keystream for seed 7F (bits 0000111011110010) descrambles to all zeros.
    run4(1'b1, 7'h00, 40'h00_0000_4F70, 4, 1'b0, o, sd);
    checks++;
    if (o[15:0] !== 16'h0000) begin
      errors++;
      $display("FAIL short_next_data: got %h required 0000", o[15:0]);
    end
    checks++;
    if (sd[3:0] !== 4'b1110) begin
      errors++;
      $display("FAIL short_next_sync: got %b required 1110", sd[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_scramble_zero();
    test_seed_zero();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_backpressure();
    test_short_descramble();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
